// File: rtl/mxu_sequencer_if.sv
// Handshake, scratch-memory and array-feed signals of the systolic matmul sequencer.
// The master modport is the sequencer side; the slave modport is the host/memory/array side.
interface mxu_sequencer_if #(
    parameter int unsigned NUM_SIZE   = 16,
    parameter int unsigned GRID_SIZE  = 2,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                                    start;
    logic [ADDR_WIDTH-1:0]                   a_base;
    logic [ADDR_WIDTH-1:0]                   b_base;
    logic [ADDR_WIDTH-1:0]                   c_base;
    logic                                    busy;
    logic                                    done;
    logic                                    mem_rd_en;
    logic [ADDR_WIDTH-1:0]                   mem_rd_addr;
    logic [NUM_SIZE-1:0]                     mem_rd_data;
    logic                                    mem_wr_en;
    logic [ADDR_WIDTH-1:0]                   mem_wr_addr;
    logic [NUM_SIZE-1:0]                     mem_wr_data;
    logic                                    array_ce;
    logic                                    array_clear;
    logic [NUM_SIZE*GRID_SIZE-1:0]           west_input;
    logic [NUM_SIZE*GRID_SIZE-1:0]           north_input;
    logic [NUM_SIZE*GRID_SIZE*GRID_SIZE-1:0] result_out;

    modport master (
        input  start, a_base, b_base, c_base, mem_rd_data, result_out,
        output busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
               array_ce, array_clear, west_input, north_input
    );

    modport slave (
        output start, a_base, b_base, c_base, mem_rd_data, result_out,
        input  busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
               array_ce, array_clear, west_input, north_input
    );
endinterface

// File: rtl/mxu_sequencer.sv
// Sequencer for the systolic matrix unit: fetches A and B into diagonally skewed
// west/north buffers, streams them into the array, then writes the product back.
module mxu_sequencer #(
    parameter int unsigned NUM_SIZE   = 16,
    parameter int unsigned GRID_SIZE  = 2,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input logic            clk,
    input logic            rst,
    mxu_sequencer_if.master bus
);
    localparam int unsigned NN     = GRID_SIZE * GRID_SIZE;
    localparam int unsigned Steps  = 3 * GRID_SIZE - 1;
    localparam int unsigned Depth  = 2 * GRID_SIZE - 1;
    localparam int unsigned CntMax = (NN > Steps) ? NN : Steps;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam int unsigned IdxW   = $clog2(GRID_SIZE);
    localparam int unsigned PosW   = $clog2(Depth);

    typedef enum logic [2:0] {
        StIdle, StLoadA, StLoadB, StClear, StStream, StWrite, StDone
    } state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [IdxW-1:0]       row_q, col_q;
    logic [ADDR_WIDTH-1:0] a_base_q, b_base_q, c_base_q;
    logic                  busy_q, done_q, ce_q, clear_q;
    logic [NUM_SIZE-1:0]   west_q  [GRID_SIZE][Depth];
    logic [NUM_SIZE-1:0]   north_q [GRID_SIZE][Depth];

    // Read data arrives one cycle late, so its buffer slot travels alongside it.
    logic                  pend_q, pend_west_q;
    logic [IdxW-1:0]       pend_lane_q;
    logic [PosW-1:0]       pend_pos_q;

    logic                      rd_en, wr_en;
    logic [ADDR_WIDTH-1:0]     rd_addr, wr_addr;
    logic [NUM_SIZE-1:0]       wr_data;
    logic [NUM_SIZE*GRID_SIZE-1:0] west_bus, north_bus;

    logic load_last, col_last;
    assign load_last = (cnt_q == CntW'(NN - 1));
    assign col_last  = (col_q == IdxW'(GRID_SIZE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            a_base_q    <= '0;
            b_base_q    <= '0;
            c_base_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ce_q        <= 1'b0;
            clear_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_west_q <= 1'b0;
            pend_lane_q <= '0;
            pend_pos_q  <= '0;
            for (int x = 0; x < GRID_SIZE; x++) begin
                for (int p = 0; p < Depth; p++) begin
                    west_q[x][p]  <= '0;
                    north_q[x][p] <= '0;
                end
            end
        end else begin
            done_q      <= 1'b0;
            clear_q     <= 1'b0;
            pend_q      <= rd_en;
            pend_west_q <= (state_q == StLoadA);
            pend_lane_q <= (state_q == StLoadA) ? row_q : col_q;
            pend_pos_q  <= PosW'(row_q) + PosW'(col_q);
            if (pend_q) begin
                if (pend_west_q) west_q[pend_lane_q][pend_pos_q]  <= bus.mem_rd_data;
                else             north_q[pend_lane_q][pend_pos_q] <= bus.mem_rd_data;
            end

            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_base_q <= bus.a_base;
                        b_base_q <= bus.b_base;
                        c_base_q <= bus.c_base;
                        cnt_q    <= '0;
                        row_q    <= '0;
                        col_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StLoadA;
                        for (int x = 0; x < GRID_SIZE; x++) begin
                            for (int p = 0; p < Depth; p++) begin
                                west_q[x][p]  <= '0;
                                north_q[x][p] <= '0;
                            end
                        end
                    end
                end
                StLoadA, StLoadB: begin
                    if (load_last) begin
                        cnt_q <= '0;
                        row_q <= '0;
                        col_q <= '0;
                        if (state_q == StLoadA) begin
                            state_q <= StLoadB;
                        end else begin
                            state_q <= StClear;
                            clear_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                        if (col_last) begin
                            col_q <= '0;
                            row_q <= row_q + IdxW'(1);
                        end else begin
                            col_q <= col_q + IdxW'(1);
                        end
                    end
                end
                StClear: begin
                    cnt_q   <= '0;
                    ce_q    <= 1'b1;
                    state_q <= StStream;
                end
                StStream: begin
                    if (cnt_q == CntW'(Steps - 1)) begin
                        cnt_q   <= '0;
                        ce_q    <= 1'b0;
                        state_q <= StWrite;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWrite: begin
                    if (load_last) begin
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        west_bus  = '0;
        north_bus = '0;
        unique case (state_q)
            StLoadA: begin
                rd_en   = 1'b1;
                rd_addr = a_base_q + ADDR_WIDTH'(cnt_q);
            end
            StLoadB: begin
                rd_en   = 1'b1;
                rd_addr = b_base_q + ADDR_WIDTH'(cnt_q);
            end
            StStream: begin
                // Steps past the last buffer column feed zeros to flush the array.
                for (int p = 0; p < Depth; p++) begin
                    if (cnt_q == CntW'(p)) begin
                        for (int x = 0; x < GRID_SIZE; x++) begin
                            west_bus[x*NUM_SIZE +: NUM_SIZE]  = west_q[x][p];
                            north_bus[x*NUM_SIZE +: NUM_SIZE] = north_q[x][p];
                        end
                    end
                end
            end
            StWrite: begin
                wr_en   = 1'b1;
                wr_addr = c_base_q + ADDR_WIDTH'(cnt_q);
                for (int k = 0; k < NN; k++) begin
                    if (cnt_q == CntW'(k)) wr_data = bus.result_out[k*NUM_SIZE +: NUM_SIZE];
                end
            end
            default: ;
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.array_ce    = ce_q;
    assign bus.array_clear = clear_q;
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = rd_addr;
    assign bus.mem_wr_en   = wr_en;
    assign bus.mem_wr_addr = wr_addr;
    assign bus.mem_wr_data = wr_data;
    assign bus.west_input  = west_bus;
    assign bus.north_input = north_bus;
endmodule

// File: tb/tb_mxu_sequencer.sv
// Self-checking bench: two sequencers (N=2, N=3) with behavioural memories and
// systolic arrays, checked against plain matrix arithmetic and skew rules.
module tb_mxu_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mxu_sequencer_if #(.NUM_SIZE(16), .GRID_SIZE(2), .ADDR_WIDTH(5)) bus2 ();
    mxu_sequencer_if #(.NUM_SIZE(16), .GRID_SIZE(3), .ADDR_WIDTH(5)) bus3 ();

    mxu_sequencer #(.NUM_SIZE(16), .GRID_SIZE(2), .ADDR_WIDTH(5)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.master)
    );
    mxu_sequencer #(.NUM_SIZE(16), .GRID_SIZE(3), .ADDR_WIDTH(5)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.master)
    );

    // Scratch memories with a backdoor preload port.
    logic [15:0] mem2 [32];
    logic [15:0] mem3 [32];
    logic        bd_we;
    int          bd_n;
    logic [4:0]  bd_addr;
    logic [15:0] bd_data;

    always @(posedge clk) begin
        if (bd_we && bd_n == 2) mem2[bd_addr] <= bd_data;
        else if (bus2.mem_wr_en) mem2[bus2.mem_wr_addr] <= bus2.mem_wr_data;
        if (bus2.mem_rd_en) bus2.mem_rd_data <= mem2[bus2.mem_rd_addr];
        if (bd_we && bd_n == 3) mem3[bd_addr] <= bd_data;
        else if (bus3.mem_wr_en) mem3[bus3.mem_wr_addr] <= bus3.mem_wr_data;
        if (bus3.mem_rd_en) bus3.mem_rd_data <= mem3[bus3.mem_rd_addr];
    end

    // Output-stationary systolic arrays: A flows east, B flows south.
    logic [15:0] pa2 [2][2], pb2 [2][2], acc2 [2][2], ain2 [2][2], bin2 [2][2];
    logic [15:0] pa3 [3][3], pb3 [3][3], acc3 [3][3], ain3 [3][3], bin3 [3][3];

    always_comb begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ain2[i][j] = (j == 0) ? bus2.west_input[i*16 +: 16] : pa2[i][(j == 0) ? 0 : j-1];
                bin2[i][j] = (i == 0) ? bus2.north_input[j*16 +: 16] : pb2[(i == 0) ? 0 : i-1][j];
            end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ain3[i][j] = (j == 0) ? bus3.west_input[i*16 +: 16] : pa3[i][(j == 0) ? 0 : j-1];
                bin3[i][j] = (i == 0) ? bus3.north_input[j*16 +: 16] : pb3[(i == 0) ? 0 : i-1][j];
            end
        bus2.result_out = '0;
        bus3.result_out = '0;
        for (int k = 0; k < 4; k++) bus2.result_out[k*16 +: 16] = acc2[k/2][k%2];
        for (int k = 0; k < 9; k++) bus3.result_out[k*16 +: 16] = acc3[k/3][k%3];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                if (bus2.array_clear) begin
                    acc2[i][j] <= '0; pa2[i][j] <= '0; pb2[i][j] <= '0;
                end else if (bus2.array_ce) begin
                    pa2[i][j]  <= ain2[i][j];
                    pb2[i][j]  <= bin2[i][j];
                    acc2[i][j] <= acc2[i][j] + ain2[i][j] * bin2[i][j];
                end
            end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                if (bus3.array_clear) begin
                    acc3[i][j] <= '0; pa3[i][j] <= '0; pb3[i][j] <= '0;
                end else if (bus3.array_ce) begin
                    pa3[i][j]  <= ain3[i][j];
                    pb3[i][j]  <= bin3[i][j];
                    acc3[i][j] <= acc3[i][j] + ain3[i][j] * bin3[i][j];
                end
            end
    end

    int    checks = 0;
    int    errors = 0;
    string cur_tag = "reset";

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s actual=%0h required=%0h", cur_tag, name, act, exp);
        end
    endtask

    logic        s_busy, s_done, s_rd, s_wr, s_ce, s_clr;
    logic [4:0]  s_rda, s_wra;
    logic [15:0] s_wrd;
    logic [47:0] s_w, s_n;

    task automatic snap(input int n);
        if (n == 2) begin
            s_busy = bus2.busy; s_done = bus2.done; s_rd = bus2.mem_rd_en; s_wr = bus2.mem_wr_en;
            s_ce = bus2.array_ce; s_clr = bus2.array_clear; s_rda = bus2.mem_rd_addr;
            s_wra = bus2.mem_wr_addr; s_wrd = bus2.mem_wr_data;
            s_w = 48'(bus2.west_input); s_n = 48'(bus2.north_input);
        end else begin
            s_busy = bus3.busy; s_done = bus3.done; s_rd = bus3.mem_rd_en; s_wr = bus3.mem_wr_en;
            s_ce = bus3.array_ce; s_clr = bus3.array_clear; s_rda = bus3.mem_rd_addr;
            s_wra = bus3.mem_wr_addr; s_wrd = bus3.mem_wr_data;
            s_w = bus3.west_input; s_n = bus3.north_input;
        end
    endtask

    task automatic chk_quiet(input int n);
        snap(n);
        chk("idle ctrl/addr/data", {s_busy, s_done, s_rd, s_wr, s_ce, s_clr, s_rda, s_wra, s_wrd}, 0);
        chk("idle west", s_w, 0);
        chk("idle north", s_n, 0);
    endtask

    task automatic set_start(input int n, input logic v);
        if (n == 2) bus2.start = v; else bus3.start = v;
    endtask

    task automatic set_bases(input int n, input logic [4:0] ab, input logic [4:0] bb,
                             input logic [4:0] cb);
        if (n == 2) begin bus2.a_base = ab; bus2.b_base = bb; bus2.c_base = cb; end
        else        begin bus3.a_base = ab; bus3.b_base = bb; bus3.c_base = cb; end
    endtask

    task automatic bd_write(input int n, input logic [4:0] addr, input logic [15:0] data);
        bd_n = n; bd_addr = addr; bd_data = data; bd_we = 1'b1;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    function automatic logic [15:0] rd_mem(input int n, input logic [4:0] addr);
        return (n == 2) ? mem2[addr] : mem3[addr];
    endfunction

    // Reference: C = A*B mod 2^16, row-major.
    function automatic logic [8:0][15:0] matmul(input int n, input logic [8:0][15:0] a,
                                                 input logic [8:0][15:0] b);
        logic [8:0][15:0] c;
        logic [15:0] s;
        c = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                s = '0;
                for (int k = 0; k < n; k++) s = s + a[i*n+k] * b[k*n+j];
                c[i*n+j] = s;
            end
        return c;
    endfunction

    // West lane x at step s carries A[x][s-x]; north lane x carries B[s-x][x].
    function automatic logic [47:0] lane_exp(input int n, input logic [8:0][15:0] m,
                                             input int s, input bit west);
        logic [47:0] v;
        v = '0;
        for (int x = 0; x < n; x++) begin
            if (s - x >= 0 && s - x < n)
                v[x*16 +: 16] = west ? m[x*n + (s-x)] : m[(s-x)*n + x];
        end
        return v;
    endfunction

    task automatic launch(input int n, input logic [4:0] ab, input logic [4:0] bb,
                          input logic [4:0] cb, input logic [8:0][15:0] a,
                          input logic [8:0][15:0] b);
        for (int k = 0; k < n*n; k++) bd_write(n, ab + 5'(k), a[k]);
        for (int k = 0; k < n*n; k++) bd_write(n, bb + 5'(k), b[k]);
        @(negedge clk);
        set_bases(n, ab, bb, cb);
        set_start(n, 1'b1);
    endtask

    task automatic run(input int n, input logic [4:0] ab, input logic [4:0] bb,
                       input logic [4:0] cb, input logic [8:0][15:0] a,
                       input logic [8:0][15:0] b, input logic [8:0][15:0] c_exp,
                       input bit noise);
        int nn = n * n;
        int cyc = 0;
        int done_cyc = 0;
        int s = 0;
        bit ok;
        logic [4:0] rq[$];
        logic [4:0] wq[$];
        launch(n, ab, bb, cb, a, b);
        while (done_cyc == 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                set_start(n, 1'b0);
                set_bases(n, 5'($urandom), 5'($urandom), 5'($urandom));
            end
            if (noise && cyc == nn + 2) set_start(n, 1'b1);
            if (noise && cyc == nn + 3) set_start(n, 1'b0);
            snap(n);
            chk("busy", s_busy, 1);
            chk("rd/wr exclusive", s_rd & s_wr, 0);
            chk("array_clear", s_clr, (cyc == 2*nn + 1) ? 1 : 0);
            if (s_rd) rq.push_back(s_rda);
            if (s_wr) wq.push_back(s_wra);
            if (s_ce) begin
                chk("west lanes", s_w, lane_exp(n, a, s, 1'b1));
                chk("north lanes", s_n, lane_exp(n, b, s, 1'b0));
                s++;
            end else begin
                chk("lanes zero outside stream", {s_w, s_n} == 96'd0, 1);
            end
            if (s_done) begin
                done_cyc = cyc;
                if (noise) set_start(n, 1'b1);
            end
        end
        chk("run length", done_cyc, 3*nn + 3*n + 1);
        chk("stream steps", s, 3*n - 1);
        @(negedge clk);
        set_start(n, 1'b0);
        snap(n);
        chk("busy/done after done", {s_busy, s_done}, 0);
        @(negedge clk);
        snap(n);
        chk("stays idle", {s_busy, s_done, s_rd, s_wr}, 0);
        ok = (rq.size() == 2*nn);
        for (int k = 0; k < 2*nn && ok; k++)
            if (rq[k] != ((k < nn) ? ab + 5'(k) : bb + 5'(k - nn))) ok = 0;
        chk("read address sequence", ok, 1);
        ok = (wq.size() == nn);
        for (int k = 0; k < nn && ok; k++) if (wq[k] != cb + 5'(k)) ok = 0;
        chk("write address sequence", ok, 1);
        for (int k = 0; k < nn; k++) chk("C word", rd_mem(n, cb + 5'(k)), c_exp[k]);
    endtask

    typedef struct packed {
        logic [3:0][15:0] a, b, c;
        logic [4:0]       ab, bb, cb;
        logic             noise;
    } vec_t;

    function automatic logic [3:0][15:0] m4(input int x0, input int x1, input int x2,
                                            input int x3);
        logic [3:0][15:0] m;
        m[0] = 16'(x0); m[1] = 16'(x1); m[2] = 16'(x2); m[3] = 16'(x3);
        return m;
    endfunction

    vec_t vecs[4];
    logic [8:0][15:0] ra, rb;
    logic [4:0] rab;

    initial begin
        rst = 1'b1; bd_we = 1'b0; bd_n = 0; bd_addr = '0; bd_data = '0;
        bus2.start = 1'b0; bus3.start = 1'b0;
        set_bases(2, 0, 0, 0);
        set_bases(3, 0, 0, 0);
        vecs[0] = '{a: m4(1, 2, 3, 4), b: m4(5, 6, 7, 8), c: m4(19, 22, 43, 50),
                    ab: 5'd0, bb: 5'd4, cb: 5'd8, noise: 1'b0};
        vecs[1] = '{a: m4(1, 0, 0, 1), b: m4(9, 8, 7, 6), c: m4(9, 8, 7, 6),
                    ab: 5'd12, bb: 5'd16, cb: 5'd20, noise: 1'b1};
        vecs[2] = '{a: m4(300, 0, 0, 300), b: m4(300, 0, 0, 300), c: m4(24464, 0, 0, 24464),
                    ab: 5'd0, bb: 5'd4, cb: 5'd8, noise: 1'b0};
        vecs[3] = '{a: m4(2, 0, 1, 3), b: m4(1, 2, 3, 4), c: m4(2, 4, 10, 14),
                    ab: 5'd30, bb: 5'd4, cb: 5'd30, noise: 1'b0};
        #12;
        chk_quiet(2);
        chk_quiet(3);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            cur_tag = $sformatf("vec%0d", i);
            run(2, vecs[i].ab, vecs[i].bb, vecs[i].cb, 144'(vecs[i].a), 144'(vecs[i].b),
                144'(vecs[i].c), vecs[i].noise);
        end

        for (int t = 0; t < 2; t++) begin
            cur_tag = $sformatf("rand2_%0d", t);
            ra = '0; rb = '0;
            for (int k = 0; k < 4; k++) begin ra[k] = 16'($urandom); rb[k] = 16'($urandom); end
            rab = 5'($urandom);
            run(2, rab, rab + 5'd4, rab + 5'd8, ra, rb, matmul(2, ra, rb), 1'b0);
        end

        // Reset in the second STREAM cycle must abort with no writes.
        cur_tag = "abort";
        for (int k = 0; k < 4; k++) bd_write(2, 5'd8 + 5'(k), 16'hdead);
        launch(2, 5'd0, 5'd4, 5'd8, 144'(vecs[0].a), 144'(vecs[0].b));
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) set_start(2, 1'b0);
        end
        snap(2);
        chk("mid-stream ce", s_ce, 1);
        #1 rst = 1'b1;
        #1 chk_quiet(2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            snap(2);
            chk("no write in reset", s_wr, 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) chk("C untouched", rd_mem(2, 5'd8 + 5'(k)), 16'hdead);
        cur_tag = "after_abort";
        run(2, vecs[0].ab, vecs[0].bb, vecs[0].cb, 144'(vecs[0].a), 144'(vecs[0].b),
            144'(vecs[0].c), 1'b0);

        for (int t = 0; t < 3; t++) begin
            cur_tag = $sformatf("rand3_%0d", t);
            for (int k = 0; k < 9; k++) begin ra[k] = 16'($urandom); rb[k] = 16'($urandom); end
            rab = 5'($urandom);
            run(3, rab, rab + 5'd9, rab + 5'd18, ra, rb, matmul(3, ra, rb), t == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mxu_sequencer.md
# mxu_sequencer

Parametrised control-and-feed block for the systolic matrix unit: on a start request it multiplies two GRID_SIZE×GRID_SIZE matrices held in the shared scratch memory and writes the product back. It fetches operands over a single-port read interface, builds diagonally skewed west/north operand buffers, streams them into the array with clock-enable control, then drains the array results to memory. It replaces the fixed 2×2, hard-staged matmul sequence in the top level, generalising grid size, word width and addressing, and adds a start/busy/done handshake.

## Interface
- NUM_SIZE, 16, operand/result word width
- GRID_SIZE, 2, array dimension N (N≥2)
- ADDR_WIDTH, 5, scratch memory address width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  request; sampled only in IDLE
- a_base, b_base, c_base  in  ADDR_WIDTH each  row-major base addresses of A, B, C
- busy  out  1  high in every state except IDLE
- done  out  1  high for exactly the one DONE cycle
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  ADDR_WIDTH  read address
- mem_rd_data  in  NUM_SIZE  read data, valid the cycle after mem_rd_en
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_WIDTH  write address
- mem_wr_data  out  NUM_SIZE  write data
- array_ce  out  1  array clock enable
- array_clear  out  1  one-cycle accumulator clear
- west_input, north_input  out  NUM_SIZE*GRID_SIZE  lane r at bits [(r+1)*NUM_SIZE-1 : r*NUM_SIZE]
- result_out  in  NUM_SIZE*GRID_SIZE*GRID_SIZE  C[i][j] at slice k=i*N+j

## Operation
- States: IDLE → LOAD_A → LOAD_B → CLEAR → STREAM → WRITE → DONE → IDLE.
- IDLE: start=1 latches the three bases and zeroes both skew buffers; next state is LOAD_A.
- Skew buffers: N lanes × (2N-1) entries each, west and north.
- LOAD_A: N² cycles. Cycle k reads a_base+k; r=k/N, c=k%N.
- Returned data is written to west[r][r+c] one cycle after the read.
- LOAD_B: N² cycles. Cycle k reads b_base+k; returned data is written to north[c][r+c].
- CLEAR: 1 cycle. Captures the final B word and asserts array_clear.
- STREAM: 3N-1 cycles with array_ce=1 and step index s=0..3N-2.
- During STREAM, lane x drives west[x][s] and north[x][s] when s≤2N-2, else 0.
- Outside STREAM, west_input and north_input are 0.
- WRITE: N² cycles. Cycle k writes slice k of result_out to c_base+k.
- DONE: done=1 for 1 cycle, then IDLE.
- Address arithmetic is mod 2^ADDR_WIDTH, so addresses wrap past the top of memory.
- Products and accumulation are done in the array. Results are NUM_SIZE bits, wrapping mod 2^NUM_SIZE.
- start is ignored in every state except IDLE, including DONE. A start held high in IDLE after DONE begins a new run.
- Base inputs may change after the start cycle; only the latched copies are used.
- mem_rd_en and mem_wr_en are never both high in the same cycle.

## Timing
- Reset (async, any state): state=IDLE; counters, skew buffers and latched bases are 0.
- Reset values of all outputs: busy, done, mem_rd_en, mem_wr_en, array_ce and array_clear are 0; all address/data/input buses are 0.
- Reset mid-run aborts the run. No further reads or writes occur; writes already done persist.
- Memory strobes, addresses and write data are combinational from state and counter.
- Edge 0 is the edge that samples start. The machine occupies:
  - LOAD_A: edges 1..N²
  - LOAD_B: the next N² edges
  - CLEAR: 1
  - STREAM: 3N-1
  - WRITE: N²
  - DONE: 1
- Total run length is 3N²+3N+1 cycles including DONE; for N=2 that is 19.
- Back-to-back runs: one IDLE cycle minimum between DONE and the next LOAD_A.

## Test plan
- N=2, A=[[1,2],[3,4]] at 0, B=[[5,6],[7,8]] at 4, c_base=8 → memory[8..11]=19,22,43,50; done pulses exactly once, 19 cycles after start.
- Identity A, B=[[9,8],[7,6]] → C=B; west/north lanes match the skew pattern on every STREAM cycle, and are 0 outside STREAM.
- Overflow: A=B=[[300,0],[0,300]] → C diagonal 24464 (90000 mod 65536), off-diagonal 0.
- Wrap: c_base=30, ADDR_WIDTH=5 → writes land at 30,31,0,1; a_base=30 reads 30,31,0,1.
- start pulsed during LOAD_B and during DONE → ignored, single done; rst asserted mid-STREAM → all outputs 0 immediately, no writes, next start completes correctly.
- GRID_SIZE=3, random 3×3 inputs → C matches the golden model; run length is 37 cycles.
